// File: rtl/instr_buffer_ctrl_if.sv
// Handshake bundle between the fill/fetch requesters and instr_buffer_ctrl.
// master = requester side, slave = the controller.
interface instr_buffer_ctrl_if #(
  parameter int Instr_word_size = 32,
  parameter int bs              = 16
);
  localparam int AW = $clog2(bs);

  logic                       push_valid;
  logic [Instr_word_size-1:0] push_data;
  logic                       push_ready;
  logic                       pop_req;
  logic                       pop_ack;
  logic                       rd_valid;
  logic                       flush;
  logic [AW-1:0]              buf_index;
  logic [Instr_word_size-1:0] buf_wdata;
  logic [AW-1:0]              count;
  logic                       full;
  logic                       empty;

  modport master (
    output push_valid, push_data, pop_req, flush,
    input  push_ready, pop_ack, rd_valid, buf_index, buf_wdata, count, full, empty
  );

  modport slave (
    input  push_valid, push_data, pop_req, flush,
    output push_ready, pop_ack, rd_valid, buf_index, buf_wdata, count, full, empty
  );
endinterface

// File: rtl/instr_buffer_ctrl.sv
// FIFO sequencer/arbiter for the single-index instruction buffer.
// Define IBUF_CTRL_RR_EN for round-robin push/pop arbitration; default is fixed pop priority.
module instr_buffer_ctrl #(
  parameter int Instr_word_size = 32,
  parameter int bs              = 16
) (
  input  logic                clk,
  input  logic                rst,
  instr_buffer_ctrl_if.slave  bus
);
  localparam int            AW      = $clog2(bs);
  localparam logic [AW-1:0] CNT_MAX = AW'(bs - 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] count_q, count_d;
  logic          rd_valid_q;
  logic          full, empty;
  logic          push_elig, pop_elig;
  logic          grant_push, grant_pop;

`ifdef IBUF_CTRL_RR_EN
  logic          last_grant_q;  // 1 = push won the last conflict
`endif

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);

  always_comb begin
    push_elig = bus.push_valid & ~full  & ~bus.flush;
    pop_elig  = bus.pop_req    & ~empty & ~bus.flush;
`ifdef IBUF_CTRL_RR_EN
    grant_pop  = pop_elig  & (~push_elig | last_grant_q);
    grant_push = push_elig & (~pop_elig  | ~last_grant_q);
`else
    grant_pop  = pop_elig;
    grant_push = push_elig & ~pop_elig;
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (grant_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (grant_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
`ifdef IBUF_CTRL_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= grant_pop;
`ifdef IBUF_CTRL_RR_EN
      if (push_elig & pop_elig) last_grant_q <= grant_push;
`endif
    end
  end

  // Idle cycles park on wr_ptr: with capacity bs-1 that slot never holds live data.
  assign bus.buf_index  = grant_pop ? rd_ptr_q : wr_ptr_q;
  assign bus.buf_wdata  = bus.push_data;
  assign bus.push_ready = grant_push;
  assign bus.pop_ack    = grant_pop;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
endmodule

// File: doc/instr_buffer_ctrl.md
# instr_buffer_ctrl

Sequencing and arbitration controller for the single-index instruction buffer.

- **Buffer behaviour:**
  - The buffer writes `Instr_in` to `buffer_index` on every clock.
  - It returns the old contents of that slot on `Instr_out` one cycle later.
- **What this block does:**
  - Turns the buffer into a FIFO shared between a fill requester (push) and a fetch requester (pop).
  - Arbitrates the single index port between them.
  - Keeps a parking slot free so unconditional writes never corrupt valid entries.
- **Placement:** between the instruction fill path and the decode/fetch stage, driving the buffer's `buffer_index` and `Instr_in`.

## Interface

Parameters:
- `Instr_word_size`, 32, instruction width in bits; must match the buffer.
- `bs`, 16, buffer depth; power of two, ≥4.
  - Usable capacity is `bs-1` entries.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `push_valid` in 1: fill requester has an instruction.
- `push_data` in `Instr_word_size`: instruction to store.
- `push_ready` out 1: push accepted this cycle (combinational).
- `pop_req` in 1: fetch requester wants the oldest instruction.
- `pop_ack` out 1: pop granted this cycle (combinational).
- `rd_valid` out 1: buffer `Instr_out` holds the popped instruction this cycle.
- `flush` in 1: synchronous discard of all entries.
- `buf_index` out `$clog2(bs)`: drives the buffer's `buffer_index`.
- `buf_wdata` out `Instr_word_size`: drives the buffer's `Instr_in`.
- `count` out `$clog2(bs)`: entries held, 0..`bs-1`.
- `full` out 1: `count == bs-1`.
- `empty` out 1: `count == 0`.

## Operation

**State:**
- `wr_ptr`, `rd_ptr`: `$clog2(bs)` bits each, wrap modulo `bs`.
- `count`.
- `rd_valid` register.
- `last_grant` bit: 0 = pop, 1 = push.

**Eligibility:**
- `push_elig = push_valid & !full & !flush`
- `pop_elig = pop_req & !empty & !flush`
- At most one grant per cycle, because the buffer has one index.

**Arbitration:**
- Only one eligible: it is granted.
- Both eligible: grant the requester opposite to `last_grant`, then update `last_grant` (see Configuration).
- `last_grant` updates only on a contended cycle.

**Index and write data:**
- Push granted: `buf_index = wr_ptr`, `buf_wdata = push_data`; `wr_ptr++`, `count++`.
- Pop granted: `buf_index = rd_ptr`, `buf_wdata = push_data` (don't-care).
  - The buffer returns the old slot contents.
  - The overwritten slot is freed by this pop.
  - `rd_ptr++`, `count--`.
- No grant: `buf_index = wr_ptr`.
  - This slot is always free, since capacity is `bs-1`.
  - The garbage write is harmless.

**Flush:**
- `wr_ptr`, `rd_ptr`, `count` ← 0 on the next edge.
- No grants in the flush cycle.

**Pointer wrap:** `bs-1 → 0` with no special handling.

## Timing

**Reset values:**
- `wr_ptr = rd_ptr = count = 0`, `rd_valid = 0`, `last_grant = 1`, so the first conflict grants pop.
- Resulting outputs: `empty = 1`, `full = 0`, `buf_index = 0`, `push_ready = pop_ack = 0` until requests arrive.

**Handshakes:**
- `push_ready` and `pop_ack` are combinational from the requests and registered state, same cycle.
- Push is accepted on the edge where `push_valid & push_ready`.
- Pop latency is 1 cycle: `rd_valid` is high in cycle N+1 for an `pop_ack` in cycle N, aligned with buffer `Instr_out`. There is no backpressure on read data.
- A pop acked in the cycle before `flush` still delivers `rd_valid` in the flush cycle.

**Boundary conditions:**
- Full: push stalls, pop proceeds.
- Empty: pop stalls, push proceeds.
- Push into an empty buffer is poppable the next cycle.
- Reset mid-operation: all state clears immediately (asynchronous). An in-flight `rd_valid` is dropped.

## Configuration

Macro `IBUF_CTRL_RR_EN`:
- **Defined:** round-robin arbitration on conflict using `last_grant`, as above.
- **Undefined:** fixed pop priority on conflict.
  - The `last_grant` register is removed.
  - Push is starved while pops are continuously eligible.

## Test plan

- **Reset then push-only:** push 0x100..0x10E into `bs=16` → `push_ready` high 15 times, `full = 1`, `count = 15`; a 16th push sees `push_ready = 0`.
- **Drain:** pop 15 times → `rd_valid` one cycle after each `pop_ack`, with data 0x100..0x10E in order; `empty = 1`; further `pop_req` gets `pop_ack = 0`.
- **Contention:** `push_valid` and `pop_req` held high with `count = 4`.
  - Macro defined: grants alternate pop, push, pop…; `count` oscillates 3/4.
  - Macro undefined: pop only, until empty.
- **Wrap-around:** 40 interleaved push/pop → data order preserved across pointer wrap; `buf_index` never equals an occupied slot on idle cycles.
- **Flush:** `count = 7`, assert `flush` alongside `push_valid` → no grant that cycle; `count = 0` and `empty = 1` next cycle.
- **Asynchronous reset mid-stream:** drop `rst` while `rd_valid` is pending → `rd_valid`, `count` and pointers are 0 before the next edge.
